pe_conv_sequencer: RTL and testbench
====================================

// Module: pe_conv_sequencer
// PURPOSE
//  Convolution tap sequencer for the PE array. Consumes the start pulse, geometry, stride
//  and padding from the configuration register block, and returns done to it. Walks every
//  output pixel and kernel tap, and issues one input-buffer address per tap to the MAC
//  datapath over a valid/ready link, flagging zero-pad taps and window boundaries.
// PARAMETERS
//  ADDR_W  16  width of tap_addr/out_addr (linear buffer index, wraps mod 2^ADDR_W)
//  DIM_W    8  width of input/output height/width fields
//  KDIM_W   4  width of kernel height/width, stride, padding fields
// PORTS
//  clk         in   1       single clock, all logic posedge
//  rst         in   1       asynchronous, active-high reset
//  start       in   1       one-cycle start pulse
//  kernel_h/w  in   KDIM_W  kernel rows/cols
//  input_h/w   in   DIM_W   input feature map rows/cols
//  stride      in   KDIM_W  stride (both axes)
//  padding     in   KDIM_W  zero padding (all four edges)
//  output_h/w  in   DIM_W   output rows/cols (supplied, not derived)
//  busy        out  1       high in RUN
//  done        out  1       one-cycle completion pulse
//  tap_valid   out  1       tap fields valid
//  tap_ready   in   1       MAC accepts tap
//  tap_addr    out  ADDR_W  iy*input_w+ix; 0 when tap_pad=1
//  tap_pad     out  1       tap lies in padding (MAC uses operand 0)
//  tap_first   out  1       first tap of window (ky=0,kx=0): MAC clears accumulator
//  tap_last    out  1       last tap of window: MAC writes result
//  out_addr    out  ADDR_W  oy*output_w+ox of current window
//  stall_cnt   out  32      backpressure cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, tap_valid, tap_pad, tap_first, tap_last = 0;
//    tap_addr, out_addr, stall_cnt = 0; counters and shadow config = 0.
//  - States: IDLE -> RUN (start; config snapshot into shadow regs, counters=0).
//    IDLE -> DONE (start with kernel_h, kernel_w, output_h, output_w or stride == 0).
//    RUN -> DONE (handshake on final tap). DONE -> IDLE unconditionally.
//  - done=1 only in DONE, for exactly 1 cycle. busy=1 only in RUN. tap_valid=busy.
//  - start is honoured only in IDLE and ignored in RUN/DONE. Config input changes
//    after the snapshot have no effect.
//  - Latency: start at cycle N -> first tap_valid at N+1. Handshake = tap_valid && tap_ready.
//    One tap per cycle at full throughput.
//  - Loop order, outer->inner: oy, ox, ky, kx; each wraps at its bound (output_h, output_w,
//    kernel_h, kernel_w). Counters advance only on handshake.
//  - iy = oy*stride + ky - padding, ix = ox*stride + kx - padding, signed, DIM_W+KDIM_W+1 bits.
//    tap_pad = (iy<0)|(iy>=input_h)|(ix<0)|(ix>=input_w).
//  - All tap_* and out_addr are decoded from registered counters and shadow config only,
//    with no combinational path from tap_ready. They are held stable while tap_valid && !tap_ready.
//  - Reset mid-RUN: immediate return to IDLE, no done pulse, next start begins a fresh pass.
// CONFIGURATION
//  PE_SEQ_PERF_EN defined:
//    - stall_cnt clears on accepted start.
//    - It increments each RUN cycle with tap_valid && !tap_ready, and saturates at 2^32-1.
//    - It holds its value after done.
//  PE_SEQ_PERF_EN undefined: stall_cnt tied to 0; no counter logic.
// TESTING
//  T1 K3x3, in 4x4, s1, p0, out 2x2, ready=1:
//     - 36 taps on consecutive cycles; first addr 0, last addr 15.
//     - tap_first on taps 0/9/18/27, tap_last on taps 8/17/26/35; out_addr 0,1,2,3.
//     - done 1 cycle after the 36th handshake.
//  T2 K3x3, in 3x3, s1, p1, out 3x3:
//     - 81 taps, 32 with tap_pad=1 and addr 0; window 0 has 5 pad taps.
//     - First non-pad tap addr 0; final tap pad=1.
//  T3 T1 config with tap_ready random 50%:
//     - Identical tap sequence; tap_* stable during stalls.
//     - With PE_SEQ_PERF_EN, stall_cnt equals the bench-counted stalls.
//  T4 K2x2, in 4x4, s2, p0, out 2x2: window first addrs 0,2,8,10; 16 taps total.
//  T5 kernel_w=0, start at N: done=1 at N+1, tap_valid never asserts, back in IDLE at N+2.
//  T6 start pulses during RUN ignored; rst after 10 handshakes:
//     - All outputs 0 and no done pulse.
//     - A new start replays T1 from addr 0.

Source files
------------

// File: rtl/pe_conv_sequencer_if.sv
// Tap link between the convolution sequencer (master) and the MAC datapath (slave).
interface pe_conv_sequencer_if #(parameter int ADDR_W = 16);
    logic              tap_valid;
    logic              tap_ready;
    logic [ADDR_W-1:0] tap_addr;
    logic              tap_pad;
    logic              tap_first;
    logic              tap_last;
    logic [ADDR_W-1:0] out_addr;

    modport master (output tap_valid, tap_addr, tap_pad, tap_first, tap_last, out_addr,
                    input  tap_ready);
    modport slave  (input  tap_valid, tap_addr, tap_pad, tap_first, tap_last, out_addr,
                    output tap_ready);
endinterface

// File: rtl/pe_conv_sequencer.sv
// Convolution tap sequencer: walks oy/ox/ky/kx and issues one buffer address per tap.
// Optional macro PE_SEQ_PERF_EN enables the saturating backpressure counter stall_cnt.
module pe_conv_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8,
    parameter int KDIM_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KDIM_W-1:0] kernel_h,
    input  logic [KDIM_W-1:0] kernel_w,
    input  logic [DIM_W-1:0]  input_h,
    input  logic [DIM_W-1:0]  input_w,
    input  logic [KDIM_W-1:0] stride,
    input  logic [KDIM_W-1:0] padding,
    input  logic [DIM_W-1:0]  output_h,
    input  logic [DIM_W-1:0]  output_w,
    output logic              busy,
    output logic              done,
    output logic [31:0]       stall_cnt,
    pe_conv_sequencer_if.master tap
);
    localparam int SW = DIM_W + KDIM_W + 1;

    typedef struct packed {
        logic [KDIM_W-1:0] kh, kw, stride, pad;
        logic [DIM_W-1:0]  ih, iw, oh, ow;
    } cfg_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    cfg_t              cfg;
    logic [DIM_W-1:0]  oy, ox;
    logic [KDIM_W-1:0] ky, kx;

    logic signed [SW-1:0] iy, ix;
    logic              pad, hs, cfg_zero;
    logic              kx_end, ky_end, ox_end, oy_end;
    logic [ADDR_W-1:0] lin_addr, win_addr;

    // Computed mod 2^SW then read as signed; the true range always fits in SW bits.
    assign iy = $signed(SW'(oy) * SW'(cfg.stride) + SW'(ky) - SW'(cfg.pad));
    assign ix = $signed(SW'(ox) * SW'(cfg.stride) + SW'(kx) - SW'(cfg.pad));
    assign pad = (iy < 0) || (iy >= $signed(SW'(cfg.ih))) ||
                 (ix < 0) || (ix >= $signed(SW'(cfg.iw)));
    assign lin_addr = ADDR_W'(iy) * ADDR_W'(cfg.iw) + ADDR_W'(ix);
    assign win_addr = ADDR_W'(oy) * ADDR_W'(cfg.ow) + ADDR_W'(ox);

    assign kx_end = (kx == cfg.kw - KDIM_W'(1));
    assign ky_end = (ky == cfg.kh - KDIM_W'(1));
    assign ox_end = (ox == cfg.ow - DIM_W'(1));
    assign oy_end = (oy == cfg.oh - DIM_W'(1));
    assign hs     = busy && tap.tap_ready;

    assign cfg_zero = (kernel_h == '0) || (kernel_w == '0) || (output_h == '0) ||
                      (output_w == '0) || (stride == '0);

    // Decode is gated by busy so stale shadow config never leaks onto the link.
    assign tap.tap_valid = busy;
    assign tap.tap_pad   = busy && pad;
    assign tap.tap_addr  = (busy && !pad) ? lin_addr : '0;
    assign tap.tap_first = busy && (ky == '0) && (kx == '0);
    assign tap.tap_last  = busy && ky_end && kx_end;
    assign tap.out_addr  = busy ? win_addr : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cfg   <= '0;
            oy    <= '0;
            ox    <= '0;
            ky    <= '0;
            kx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cfg <= '{kh: kernel_h, kw: kernel_w, stride: stride, pad: padding,
                                 ih: input_h, iw: input_w, oh: output_h, ow: output_w};
                        oy  <= '0;
                        ox  <= '0;
                        ky  <= '0;
                        kx  <= '0;
                        if (cfg_zero) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (!kx_end) kx <= kx + KDIM_W'(1);
                        else begin
                            kx <= '0;
                            if (!ky_end) ky <= ky + KDIM_W'(1);
                            else begin
                                ky <= '0;
                                if (!ox_end) ox <= ox + DIM_W'(1);
                                else begin
                                    ox <= '0;
                                    if (!oy_end) oy <= oy + DIM_W'(1);
                                    else begin
                                        oy    <= '0;
                                        state <= DONE;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PE_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == IDLE && start)
            stall_cnt <= '0;
        else if (busy && !tap.tap_ready && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pe_conv_sequencer.sv
// Self-checking bench for pe_conv_sequencer: directed configs plus random backpressure
// checked against a loop-nest reference model of the tap stream.
module tb_pe_conv_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  kernel_h, kernel_w, stride, padding;
    logic [7:0]  input_h, input_w, output_h, output_w;
    logic        busy, done;
    logic [31:0] stall_cnt;

    pe_conv_sequencer_if #(.ADDR_W(16)) tap_if ();

    pe_conv_sequencer #(.ADDR_W(16), .DIM_W(8), .KDIM_W(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .kernel_h(kernel_h), .kernel_w(kernel_w),
        .input_h(input_h), .input_w(input_w),
        .stride(stride), .padding(padding),
        .output_h(output_h), .output_w(output_w),
        .busy(busy), .done(done), .stall_cnt(stall_cnt),
        .tap(tap_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        bit pad;
        bit first;
        bit last;
        int oaddr;
    } tap_t;

    tap_t expq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic build_model(input int kh, kw, ih, iw, s, p, oh, ow);
        tap_t t;
        expq.delete();
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < kh; ky++)
                    for (int kx = 0; kx < kw; kx++) begin
                        int iy = oy * s + ky - p;
                        int ix = ox * s + kx - p;
                        t.pad   = (iy < 0) || (iy >= ih) || (ix < 0) || (ix >= iw);
                        t.addr  = t.pad ? 0 : ((iy * iw + ix) & 16'hFFFF);
                        t.first = (ky == 0) && (kx == 0);
                        t.last  = (ky == kh - 1) && (kx == kw - 1);
                        t.oaddr = (oy * ow + ox) & 16'hFFFF;
                        expq.push_back(t);
                    end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  64'(busy), 0);
        chk({tag, "_done"},  64'(done), 0);
        chk({tag, "_valid"}, 64'(tap_if.tap_valid), 0);
        chk({tag, "_pad"},   64'(tap_if.tap_pad), 0);
        chk({tag, "_first"}, 64'(tap_if.tap_first), 0);
        chk({tag, "_last"},  64'(tap_if.tap_last), 0);
        chk({tag, "_addr"},  64'(tap_if.tap_addr), 0);
        chk({tag, "_oaddr"}, 64'(tap_if.out_addr), 0);
    endtask

    // Runs one pass; stop_after>0 leaves the DUT mid-RUN after that many handshakes.
    task automatic run_pass(input string name, input int kh, kw, ih, iw, s, p, oh, ow,
                            input int pct, input int stop_after, input bit poke_start);
        int idx = 0, stalls = 0, cyc = 0;
        bit zero;
        logic [31:0] exp_stall;
        kernel_h = 4'(kh); kernel_w = 4'(kw); input_h = 8'(ih); input_w = 8'(iw);
        stride = 4'(s); padding = 4'(p); output_h = 8'(oh); output_w = 8'(ow);
        build_model(kh, kw, ih, iw, s, p, oh, ow);
        zero = (kh == 0) || (kw == 0) || (oh == 0) || (ow == 0) || (s == 0);
        tap_if.tap_ready = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        // scramble config after the snapshot; it must have no effect
        kernel_h = 4'($urandom); kernel_w = 4'($urandom); input_h = 8'($urandom);
        input_w = 8'($urandom); stride = 4'($urandom); padding = 4'($urandom);
        output_h = 8'($urandom); output_w = 8'($urandom);
        if (zero) begin
            chk({name, "_zdone"}, 64'(done), 1);
            chk({name, "_zbusy"}, 64'(busy), 0);
            chk({name, "_zvalid"}, 64'(tap_if.tap_valid), 0);
            @(negedge clk);
            chk_idle({name, "_zidle"});
            return;
        end
        while (idx < expq.size() && cyc < 4000) begin
            chk($sformatf("%s_valid%0d", name, idx), 64'(tap_if.tap_valid), 1);
            chk($sformatf("%s_addr%0d", name, idx), 64'(tap_if.tap_addr), 64'(expq[idx].addr));
            chk($sformatf("%s_pad%0d", name, idx), 64'(tap_if.tap_pad), 64'(expq[idx].pad));
            chk($sformatf("%s_first%0d", name, idx), 64'(tap_if.tap_first), 64'(expq[idx].first));
            chk($sformatf("%s_last%0d", name, idx), 64'(tap_if.tap_last), 64'(expq[idx].last));
            chk($sformatf("%s_oaddr%0d", name, idx), 64'(tap_if.out_addr), 64'(expq[idx].oaddr));
            chk($sformatf("%s_nodone%0d", name, idx), 64'(done), 0);
            tap_if.tap_ready = ($urandom_range(99) < pct);
            start = poke_start ? 1'($urandom_range(1)) : 1'b0;
            if (tap_if.tap_ready) idx++;
            else stalls++;
            cyc++;
            @(negedge clk);
            if (stop_after > 0 && idx == stop_after) begin
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
        tap_if.tap_ready = 1'b0;
        chk({name, "_count"}, 64'(idx), 64'(expq.size()));
`ifdef PE_SEQ_PERF_EN
        exp_stall = 32'(stalls);
`else
        exp_stall = 32'd0;
`endif
        chk({name, "_done"}, 64'(done), 1);
        chk({name, "_busy_end"}, 64'(busy), 0);
        chk({name, "_valid_end"}, 64'(tap_if.tap_valid), 0);
        chk({name, "_stall"}, 64'(stall_cnt), 64'(exp_stall));
        @(negedge clk);
        chk_idle({name, "_post"});
        chk({name, "_stall_hold"}, 64'(stall_cnt), 64'(exp_stall));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tap_if.tap_ready = 1'b0;
        kernel_h = '0; kernel_w = '0; input_h = '0; input_w = '0;
        stride = '0; padding = '0; output_h = '0; output_w = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset_stall", 64'(stall_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        run_pass("t1", 3, 3, 4, 4, 1, 0, 2, 2, 100, 0, 1'b0);
        run_pass("t2", 3, 3, 3, 3, 1, 1, 3, 3, 100, 0, 1'b0);
        run_pass("t3", 3, 3, 4, 4, 1, 0, 2, 2, 50, 0, 1'b0);
        run_pass("t4", 2, 2, 4, 4, 2, 0, 2, 2, 70, 0, 1'b0);
        run_pass("t5", 3, 0, 4, 4, 1, 0, 2, 2, 100, 0, 1'b0);
        run_pass("t5s", 3, 3, 4, 4, 0, 0, 2, 2, 100, 0, 1'b0);

        run_pass("t6a", 3, 3, 4, 4, 1, 0, 2, 2, 100, 10, 1'b1);
        rst = 1'b1;
        #1;
        chk_idle("t6_rst");
        chk("t6_rst_stall", 64'(stall_cnt), 0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_nodone", 64'(done), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk_idle("t6_idle");
        run_pass("t6b", 3, 3, 4, 4, 1, 0, 2, 2, 100, 0, 1'b0);
        run_pass("t6c", 3, 3, 4, 4, 1, 0, 2, 2, 60, 0, 1'b1);

        for (int r = 0; r < 8; r++)
            run_pass($sformatf("rnd%0d", r),
                     $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 6),
                     $urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(0, 2),
                     $urandom_range(1, 3), $urandom_range(1, 3),
                     $urandom_range(30, 100), 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
